// File: rtl/aidc_lite_comp_buf_ex.sv
// aidc_lite_comp_buf_ex: byte-enabled staging buffer with valid tracking, write-first registered read, occupancy count
module aidc_lite_comp_buf_ex #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              wren_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BE_W-1:0]   wbe_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rden_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              rhit_o,
  output logic [ADDR_W:0]   cnt_o,
  output logic              full_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld, vld_cl, vld_nx;
  logic wr_en, hit;
  logic [DATA_W-1:0] base, merged, rd_nx;
  logic [ADDR_W:0] cnt;
  // clear-then-write next state; invalid entries merge onto zero; same-address read forwards merged data
  always_comb begin
    wr_en = wren_i && (wbe_i != '0);
    vld_cl = clear_i ? '0 : vld;
    base = vld_cl[waddr_i] ? mem[waddr_i] : '0;
    merged = base;
    for (int k = 0; k < BE_W; k++)
      if (wbe_i[k]) merged[8*k +: 8] = wdata_i[8*k +: 8];
    vld_nx = wr_en ? (vld_cl | (DEPTH'(1) << waddr_i)) : vld_cl;
    hit = vld_nx[raddr_i];
    rd_nx = (wr_en && waddr_i == raddr_i) ? merged : (hit ? mem[raddr_i] : '0);
  end
  // popcount of the valid vector
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (ADDR_W+1)'(vld[i]);
  end
  assign cnt_o = cnt;
  assign full_o = cnt == (ADDR_W+1)'(DEPTH);
  // storage array, deliberately not reset
  always_ff @(posedge clk)
    if (wr_en) mem[waddr_i] <= merged;
  // valid bits and registered read port; rdata/rhit hold when no read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      rvalid_o <= 1'b0;
      rhit_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      vld <= vld_nx;
      rvalid_o <= rden_i;
      if (rden_i) begin
        rdata_o <= rd_nx;
        rhit_o <= hit;
      end
    end
endmodule

// File: tb/tb_aidc_lite_comp_buf_ex.sv
// tb_aidc_lite_comp_buf_ex: directed checks of the staging buffer at 64x16 and 32x8
module tb_aidc_lite_comp_buf_ex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear, wren, rden;
  logic [3:0] waddr, raddr;
  logic [7:0] wbe;
  logic [63:0] wdata, rdata;
  logic rvalid, rhit, full;
  logic [4:0] cnt;
  logic clear2, wren2, rden2;
  logic [2:0] waddr2, raddr2;
  logic [3:0] wbe2;
  logic [31:0] wdata2, rdata2;
  logic rvalid2, rhit2, full2;
  logic [3:0] cnt2;
  int n_assert = 0;
  int n_fail = 0;

  aidc_lite_comp_buf_ex dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .wren_i(wren), .waddr_i(waddr),
    .wbe_i(wbe), .wdata_i(wdata), .rden_i(rden), .raddr_i(raddr),
    .rdata_o(rdata), .rvalid_o(rvalid), .rhit_o(rhit), .cnt_o(cnt), .full_o(full)
  );

  aidc_lite_comp_buf_ex #(.DATA_W(32), .DEPTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear2), .wren_i(wren2), .waddr_i(waddr2),
    .wbe_i(wbe2), .wdata_i(wdata2), .rden_i(rden2), .raddr_i(raddr2),
    .rdata_o(rdata2), .rvalid_o(rvalid2), .rhit_o(rhit2), .cnt_o(cnt2), .full_o(full2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    {clear, wren, rden, waddr, raddr, wbe, wdata} = '0;
    {clear2, wren2, rden2, waddr2, raddr2, wbe2, wdata2} = '0;
    tick();
    tick();
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_rhit", 64'(rhit), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_full", 64'(full), 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      rden = 1'b1;
      raddr = 4'(i);
      tick();
      chk("empty_rvalid", 64'(rvalid), 1);
      chk("empty_rhit", 64'(rhit), 0);
      chk("empty_rdata", rdata, 0);
      chk("empty_cnt", 64'(cnt), 0);
    end
    rden = 1'b0;
    tick();
    chk("idle_rvalid", 64'(rvalid), 0);

    wren = 1'b1; waddr = 4'd3; wbe = 8'h0F; wdata = 64'h1122334455667788;
    tick();
    wren = 1'b0; rden = 1'b1; raddr = 4'd3;
    tick();
    chk("lo_rdata", rdata, 64'h0000000055667788);
    chk("lo_rhit", 64'(rhit), 1);
    chk("lo_cnt", 64'(cnt), 1);

    wren = 1'b1; waddr = 4'd3; wbe = 8'hF0; wdata = 64'hAABBCCDD00000000;
    rden = 1'b1; raddr = 4'd3;
    tick();
    chk("fwd_rdata", rdata, 64'hAABBCCDD55667788);
    chk("fwd_rhit", 64'(rhit), 1);
    chk("fwd_cnt", 64'(cnt), 1);
    wren = 1'b0; rden = 1'b0;
    tick();
    chk("hold_rvalid", 64'(rvalid), 0);
    chk("hold_rdata", rdata, 64'hAABBCCDD55667788);
    chk("hold_rhit", 64'(rhit), 1);

    for (int i = 0; i < 16; i++) begin
      wren = 1'b1; waddr = 4'(i); wbe = 8'hFF; wdata = 64'(i);
      tick();
    end
    wren = 1'b0;
    chk("fill_cnt", 64'(cnt), 16);
    chk("fill_full", 64'(full), 1);

    clear = 1'b1; wren = 1'b1; waddr = 4'd5; wbe = 8'h01; wdata = 64'hEE;
    rden = 1'b1; raddr = 4'd5;
    tick();
    chk("clr_cnt", 64'(cnt), 1);
    chk("clr_full", 64'(full), 0);
    chk("clr_fwd_rdata", rdata, 64'hEE);
    chk("clr_fwd_rhit", 64'(rhit), 1);
    clear = 1'b0; wren = 1'b0; raddr = 4'd5;
    tick();
    chk("clr_rd5_rdata", rdata, 64'hEE);
    chk("clr_rd5_rhit", 64'(rhit), 1);
    raddr = 4'd4;
    tick();
    chk("clr_rd4_rdata", rdata, 0);
    chk("clr_rd4_rhit", 64'(rhit), 0);

    rden = 1'b0;
    wren = 1'b1; waddr = 4'd7; wbe = 8'h00; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("nobe_cnt", 64'(cnt), 1);
    wren = 1'b0; rden = 1'b1; raddr = 4'd7;
    tick();
    chk("nobe_rhit", 64'(rhit), 0);
    chk("nobe_rdata", rdata, 0);

    rden = 1'b0;
    wren = 1'b1; waddr = 4'd5; wbe = 8'h02; wdata = 64'h1100;
    tick();
    wren = 1'b0; rden = 1'b1; raddr = 4'd5;
    tick();
    chk("merge_rdata", rdata, 64'h11EE);
    chk("merge_rhit", 64'(rhit), 1);
    chk("merge_rvalid", 64'(rvalid), 1);

    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid), 0);
    chk("mid_rst_cnt", 64'(cnt), 0);
    chk("mid_rst_rhit", 64'(rhit), 0);
    tick();
    chk("mid_rst_hold_rvalid", 64'(rvalid), 0);
    rden = 1'b0;
    rst_n = 1'b1;
    tick();
    rden = 1'b1; raddr = 4'd5;
    tick();
    chk("post_rst_rvalid", 64'(rvalid), 1);
    chk("post_rst_rhit", 64'(rhit), 0);
    chk("post_rst_rdata", rdata, 0);
    rden = 1'b0;

    wren2 = 1'b1; waddr2 = 3'd2; wbe2 = 4'h3; wdata2 = 32'hDEADBEEF;
    tick();
    wren2 = 1'b0; rden2 = 1'b1; raddr2 = 3'd2;
    tick();
    chk("n32_lo_rdata", 64'(rdata2), 64'h0000BEEF);
    chk("n32_lo_rhit", 64'(rhit2), 1);
    chk("n32_lo_cnt", 64'(cnt2), 1);
    wren2 = 1'b1; wbe2 = 4'hC; wdata2 = 32'h12340000;
    tick();
    chk("n32_fwd_rdata", 64'(rdata2), 64'h1234BEEF);
    chk("n32_fwd_cnt", 64'(cnt2), 1);
    rden2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wren2 = 1'b1; waddr2 = 3'(i); wbe2 = 4'hF; wdata2 = 32'(i);
      tick();
    end
    wren2 = 1'b0;
    chk("n32_fill_cnt", 64'(cnt2), 8);
    chk("n32_fill_full", 64'(full2), 1);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("n32_clr_cnt", 64'(cnt2), 0);
    chk("n32_clr_full", 64'(full2), 0);
    rden2 = 1'b1; raddr2 = 3'd2;
    tick();
    chk("n32_clr_rhit", 64'(rhit2), 0);
    chk("n32_clr_rdata", 64'(rdata2), 0);
    rden2 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/aidc_lite_comp_buf_ex.md
# aidc_lite_comp_buf_ex

Parametrised compression-side staging buffer for the AIDC-Lite datapath: a DEPTH x DATA_W single-clock register array with byte-enabled writes, a registered read port, and per-entry valid tracking. It replaces the fixed 16 x 64 compression buffer. New behaviour over the fixed version:
- synchronous bulk clear;
- deterministic zero-fill of never-written bytes;
- write-first forwarding on same-address read/write;
- hit flag per read;
- occupancy count and full flag for the compressor controller.

## Interface
Parameters:
- DATA_W, 64, data width in bits; multiple of 8, at least 8
- DEPTH, 16, number of entries; power of two, at least 2
- ADDR_W, $clog2(DEPTH), derived (localparam), address width
- BE_W, DATA_W/8, derived (localparam), byte-enable width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of all valid bits
- wren_i  in  1  write request
- waddr_i  in  ADDR_W  write entry index
- wbe_i  in  BE_W  byte enables; bit k covers wdata_i[8k+7:8k]
- wdata_i  in  DATA_W  write data
- rden_i  in  1  read request
- raddr_i  in  ADDR_W  read entry index
- rdata_o  out  DATA_W  read data, registered
- rvalid_o  out  1  one-cycle pulse; rdata_o/rhit_o valid
- rhit_o  out  1  read entry was valid at the read
- cnt_o  out  ADDR_W+1  number of valid entries
- full_o  out  1  cnt_o == DEPTH

## Operation
- State:
  - storage array mem[DEPTH], not reset;
  - valid vector vld[DEPTH];
  - output registers rdata_o, rvalid_o, rhit_o.
- Reset (rst_n low, asynchronous): vld, rdata_o, rvalid_o, rhit_o all 0. Therefore cnt_o = 0 and full_o = 0. mem contents are don't-care.
- Write, effective when wren_i = 1 and wbe_i != 0:
  - Base value is mem[waddr_i] if vld[waddr_i] = 1 after clear is applied, otherwise all-zero.
  - Enabled bytes are replaced from wdata_i; disabled bytes keep the base.
  - The result is stored and vld[waddr_i] is set.
  - wren_i = 1 with wbe_i = 0 is a no-op; the valid bit is unchanged.
- Clear: clear_i = 1 zeroes all vld bits at the edge.
- Priority within one cycle is clear first, then write. Clear and write together leave exactly the written entry valid, with its unenabled bytes zero, and cnt_o = 1.
- Read, when rden_i = 1: the read result is registered.
  - rhit_o = 1 if the entry is valid after this cycle's clear and write are applied; rdata_o = that entry's post-write contents.
  - Otherwise rhit_o = 0 and rdata_o = 0.
  - Consequences:
    - Same-address write and read: write-first. The read returns the merged data with rhit_o = 1.
    - Read with clear_i: returns 0 with rhit_o = 0 unless the same cycle's write targets raddr_i.
- rden_i = 0: rvalid_o = 0, and rdata_o and rhit_o hold their previous values.
- cnt_o = popcount(vld), combinational from the vld register. full_o = (cnt_o == DEPTH).
- Read and write ports are independent. A read and a write to different addresses in the same cycle do not interact.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible to a read issued in cycle N+1. Same-cycle reads see it via forwarding.
- Read latency: 1 cycle. With rden_i high in cycle N, rdata_o, rhit_o and rvalid_o are valid after edge N, during cycle N+1.
- Back-to-back reads every cycle are supported, giving rvalid_o continuously high.
- cnt_o and full_o update at the same edge as vld.
- There is no backpressure. Every request is accepted in the cycle it is presented.
- Reset asserted mid-operation:
  - an in-flight read result is dropped (rvalid_o forced 0);
  - all entries become invalid;
  - the first read after reset release returns rhit_o = 0, rdata_o = 0.

## Test plan
- Reset, then read each address 0..DEPTH-1 -> rvalid_o pulses one cycle after each request; rhit_o = 0, rdata_o = 0, cnt_o = 0.
- Write addr 3, wbe = 0x0F, data 0x1122334455667788; next cycle read addr 3 -> rdata_o = 0x0000000055667788, rhit_o = 1, cnt_o = 1.
- Then write addr 3, wbe = 0xF0, data 0xAABBCCDD00000000 with a same-cycle read of addr 3 -> rdata_o = 0xAABBCCDD55667788 one cycle later; cnt_o stays 1.
- Write all 16 addresses with data = addr -> full_o = 1, cnt_o = 16. Then clear_i together with a write to addr 5 (wbe = 0x01, data 0xEE) -> cnt_o = 1; read addr 5 -> 0xEE, rhit_o = 1; read addr 4 -> 0, rhit_o = 0.
- wren_i with wbe = 0 to an invalid addr 7 -> cnt_o is unchanged; read addr 7 -> rhit_o = 0.
- Issue a read, then assert rst_n low before the rising edge that registers the result -> rvalid_o = 0 and cnt_o = 0. After release, reading a previously written address returns rhit_o = 0.
- Repeat a subset with DATA_W = 32, DEPTH = 8 -> cnt_o width 4, full at 8; byte-merge behaviour is identical.
